// File: rtl/eth_frame_tx.sv
// eth_frame_tx: serializes a 14-byte Ethernet header (dest, src, type) followed by a byte-wide payload stream.
// Build option ETH_TX_PAD_EN zero-pads short payloads up to the minimum Ethernet payload length.
module eth_frame_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_eth_hdr_valid,
    output logic        s_eth_hdr_ready,
    input  logic [47:0] s_eth_dest_mac,
    input  logic [47:0] s_eth_src_mac,
    input  logic [15:0] s_eth_type,
    input  logic [7:0]  s_eth_payload_axis_tdata,
    input  logic        s_eth_payload_axis_tvalid,
    output logic        s_eth_payload_axis_tready,
    input  logic        s_eth_payload_axis_tlast,
    input  logic        s_eth_payload_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy
);
    localparam int unsigned HDR_BYTES = 14;
    localparam int unsigned HDR_W     = 8 * HDR_BYTES;
    localparam int unsigned HDR_CNT_W = 4;
`ifdef ETH_TX_PAD_EN
    localparam int unsigned MIN_PAYLOAD = 46;
    localparam int unsigned PAY_CNT_W   = 6;
`endif

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
`ifdef ETH_TX_PAD_EN
    localparam logic [1:0] ST_PAD     = 2'd3;
`endif

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [HDR_W-1:0]     hdr_sr;
    logic [HDR_CNT_W-1:0] hdr_cnt;
    logic                 load_ok;
    logic                 hdr_load;
    logic                 out_load;
    logic [7:0]           out_data;
    logic                 out_last;
    logic                 out_user;
`ifdef ETH_TX_PAD_EN
    logic [PAY_CNT_W-1:0] pay_cnt;
    logic [PAY_CNT_W-1:0] pay_cnt_inc;
    logic                 pad_user;
    logic                 pay_step;
    logic                 pay_last_beat;

    assign pay_cnt_inc = (pay_cnt == '1) ? pay_cnt : pay_cnt + PAY_CNT_W'(1);
`endif

    assign load_ok = !m_axis_tvalid || m_axis_tready;
    assign busy    = (state != ST_IDLE) || m_axis_tvalid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshakes and output-register load selection
    always_comb begin
        state_next                = state;
        s_eth_hdr_ready           = 1'b0;
        s_eth_payload_axis_tready = 1'b0;
        hdr_load                  = 1'b0;
        out_load                  = 1'b0;
        out_data                  = hdr_sr[HDR_W-1 -: 8];
        out_last                  = 1'b0;
        out_user                  = 1'b0;
`ifdef ETH_TX_PAD_EN
        pay_step                  = 1'b0;
        pay_last_beat             = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                s_eth_hdr_ready = !rst;
                if (s_eth_hdr_valid) begin
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (load_ok) begin
                    hdr_load = 1'b1;
                    out_load = 1'b1;
                    if (hdr_cnt == HDR_CNT_W'(HDR_BYTES - 1)) begin
                        state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                s_eth_payload_axis_tready = load_ok;
                if (load_ok && s_eth_payload_axis_tvalid) begin
                    out_load = 1'b1;
                    out_data = s_eth_payload_axis_tdata;
                    out_last = s_eth_payload_axis_tlast;
                    out_user = s_eth_payload_axis_tuser && s_eth_payload_axis_tlast;
`ifdef ETH_TX_PAD_EN
                    pay_step      = 1'b1;
                    pay_last_beat = s_eth_payload_axis_tlast;
                    if (s_eth_payload_axis_tlast) begin
                        if (pay_cnt_inc < PAY_CNT_W'(MIN_PAYLOAD)) begin
                            out_last   = 1'b0;
                            out_user   = 1'b0;
                            state_next = ST_PAD;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
`else
                    if (s_eth_payload_axis_tlast) begin
                        state_next = ST_IDLE;
                    end
`endif
                end
            end
`ifdef ETH_TX_PAD_EN
            ST_PAD: begin
                if (load_ok) begin
                    out_load = 1'b1;
                    out_data = 8'h00;
                    pay_step = 1'b1;
                    if (pay_cnt_inc == PAY_CNT_W'(MIN_PAYLOAD)) begin
                        out_last   = 1'b1;
                        out_user   = pad_user;
                        state_next = ST_IDLE;
                    end
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Header shift register, counters and the single-entry output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_sr        <= '0;
            hdr_cnt       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
`ifdef ETH_TX_PAD_EN
            pay_cnt       <= '0;
            pad_user      <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE && s_eth_hdr_valid) begin
                hdr_sr  <= {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
                hdr_cnt <= '0;
`ifdef ETH_TX_PAD_EN
                pay_cnt <= '0;
`endif
            end else if (hdr_load) begin
                hdr_sr  <= {hdr_sr[HDR_W-9:0], 8'h00};
                hdr_cnt <= hdr_cnt + HDR_CNT_W'(1);
            end
`ifdef ETH_TX_PAD_EN
            if (pay_step) begin
                pay_cnt <= pay_cnt_inc;
            end
            if (pay_last_beat) begin
                pad_user <= s_eth_payload_axis_tuser;
            end
`endif
            if (out_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= out_data;
                m_axis_tlast  <= out_last;
                m_axis_tuser  <= out_user;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_eth_frame_tx.sv
// tb_eth_frame_tx: directed and randomized frames checked against a byte-list reference model.
// Honours ETH_TX_PAD_EN the same way the design does.
module tb_eth_frame_tx;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        s_eth_hdr_valid;
    logic        s_eth_hdr_ready;
    logic [47:0] s_eth_dest_mac;
    logic [47:0] s_eth_src_mac;
    logic [15:0] s_eth_type;
    logic [7:0]  s_eth_payload_axis_tdata;
    logic        s_eth_payload_axis_tvalid;
    logic        s_eth_payload_axis_tready;
    logic        s_eth_payload_axis_tlast;
    logic        s_eth_payload_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;

    always #5 clk = ~clk;

    eth_frame_tx dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_eth_payload_axis_tdata),
        .s_eth_payload_axis_tvalid (s_eth_payload_axis_tvalid),
        .s_eth_payload_axis_tready (s_eth_payload_axis_tready),
        .s_eth_payload_axis_tlast  (s_eth_payload_axis_tlast),
        .s_eth_payload_axis_tuser  (s_eth_payload_axis_tuser),
        .m_axis_tdata              (m_axis_tdata),
        .m_axis_tvalid             (m_axis_tvalid),
        .m_axis_tready             (m_axis_tready),
        .m_axis_tlast              (m_axis_tlast),
        .m_axis_tuser              (m_axis_tuser),
        .busy                      (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_mode = 0;
    int ready_phase = 0;

    logic [9:0] got[$];
    logic [9:0] exp_q[$];
    int         got_rd = 0;
    int hdr_acc_cnt = 0, hdr_acc_cyc = 0, pay_last_cyc = 0;
    int tl_cnt = 0, run = 0, last_run = 0;
    int stall_chk = 0, stall_viol = 0, busy_low = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;
    logic       watch_busy = 1'b0;
    int         tl_base = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observes both interfaces away from the active edge
    always @(negedge clk) begin
        if (s_eth_hdr_valid && s_eth_hdr_ready) begin
            hdr_acc_cnt = hdr_acc_cnt + 1;
            hdr_acc_cyc = cyc;
        end
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tready && s_eth_payload_axis_tlast)
            pay_last_cyc = cyc;
        if (prev_stall && !rst) begin
            stall_chk = stall_chk + 1;
            if (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} != prev_beat)
                stall_viol = stall_viol + 1;
        end
        if (m_axis_tvalid && !m_axis_tready) begin
            stall_chk = stall_chk + 1;
            if (s_eth_payload_axis_tready) stall_viol = stall_viol + 1;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        run = m_axis_tvalid ? run + 1 : 0;
        if (m_axis_tvalid && m_axis_tready) begin
            got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            if (m_axis_tlast) begin
                last_run = run;
                tl_cnt   = tl_cnt + 1;
            end
        end
        if (watch_busy && (tl_cnt - tl_base) < 2 && !busy) busy_low = busy_low + 1;
    end

    // Downstream ready: always on, 1,0,0,1 pattern, or random
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       m_axis_tready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
            ready_phase = ready_phase + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: header bytes MSB-first, payload, optional zero padding, flags on final byte
    function automatic void add_exp(input logic [47:0] d, input logic [47:0] s,
                                    input logic [15:0] t, input byte_q_t pl, input bit ul);
        logic [111:0] h;
        int n;
        int total;
        logic [7:0] b;
        logic lst;
        h = {d, s, t};
        n = pl.size();
        total = n;
`ifdef ETH_TX_PAD_EN
        if (total < 46) total = 46;
`endif
        for (int i = 0; i < 14; i++) exp_q.push_back({2'b00, h[111 - 8*i -: 8]});
        for (int i = 0; i < total; i++) begin
            b   = (i < n) ? pl[i] : 8'h00;
            lst = (i == total - 1);
            exp_q.push_back({lst & ul, lst, b});
        end
    endfunction

    task automatic start_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        s_eth_dest_mac  = d;
        s_eth_src_mac   = s;
        s_eth_type      = t;
        s_eth_hdr_valid = 1'b1;
    endtask

    task automatic wait_hdr(input string tag);
        int n = hdr_acc_cnt;
        int g = 0;
        while (hdr_acc_cnt == n && g < 500) begin
            tick();
            g++;
        end
        check({tag, "_hdr_accept"}, int'(hdr_acc_cnt != n), 1);
    endtask

    task automatic send_payload(input string tag, input byte_q_t pl, input bit ul, input int mid);
        logic ok;
        int g;
        for (int i = 0; i < pl.size(); i++) begin
            s_eth_payload_axis_tdata  = pl[i];
            s_eth_payload_axis_tvalid = 1'b1;
            s_eth_payload_axis_tlast  = (i == pl.size() - 1);
            s_eth_payload_axis_tuser  = (i == pl.size() - 1) ? ul : (i == mid);
            g = 0;
            do begin
                @(negedge clk);
                ok = s_eth_payload_axis_tready;
                tick();
                g++;
            end while (!ok && g < 2000);
            if (!ok) begin
                check({tag, "_payload_timeout"}, 0, 1);
                break;
            end
        end
        s_eth_payload_axis_tvalid = 1'b0;
        s_eth_payload_axis_tlast  = 1'b0;
        s_eth_payload_axis_tuser  = 1'b0;
    endtask

    task automatic compare(input string tag);
        int g = 0;
        while (got.size() - got_rd < exp_q.size() && g < 4000) begin
            tick();
            g++;
        end
        repeat (3) tick();
        check({tag, "_len"}, got.size() - got_rd, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (got_rd + i < got.size())
                check($sformatf("%s_b%0d", tag, i), int'(got[got_rd + i]), int'(exp_q[i]));
        check({tag, "_stall_stable"}, stall_viol, 0);
        got_rd = got.size();
        exp_q.delete();
    endtask

    task automatic rand_payload(output byte_q_t pl, input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        byte_q_t pl, pl2;
        logic [47:0] d, s, d2, s2;
        logic [15:0] t, t2;
        int base, tl_before, bu;

        rst = 1'b1;
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac = '0;
        s_eth_src_mac = '0;
        s_eth_type = '0;
        s_eth_payload_axis_tdata = '0;
        s_eth_payload_axis_tvalid = 1'b0;
        s_eth_payload_axis_tlast = 1'b0;
        s_eth_payload_axis_tuser = 1'b0;
        repeat (3) tick();
        check("rst_tvalid", int'(m_axis_tvalid), 0);
        check("rst_tdata", int'(m_axis_tdata), 0);
        check("rst_tlast", int'(m_axis_tlast), 0);
        check("rst_tuser", int'(m_axis_tuser), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pay_ready", int'(s_eth_payload_axis_tready), 0);
        check("rst_hdr_ready", int'(s_eth_hdr_ready), 0);
        rst = 1'b0;
        tick();
        check("idle_hdr_ready", int'(s_eth_hdr_ready), 1);
        check("idle_busy", int'(busy), 0);

        // Directed frame at full rate
        d = 48'h0102_0304_0506; s = 48'h0A0B_0C0D_0E0F; t = 16'h0800;
        pl = '{8'hAA, 8'hBB, 8'hCC};
        ready_mode = 0;
        add_exp(d, s, t, pl, 1'b0);
        start_hdr(d, s, t);
        wait_hdr("t1");
        s_eth_hdr_valid = 1'b0;
        send_payload("t1", pl, 1'b0, -1);
        compare("t1");
`ifdef ETH_TX_PAD_EN
        check("t1_consecutive", last_run, 60);
`else
        check("t1_consecutive", last_run, 17);
`endif

        // Same frame under 1,0,0,1 backpressure
        base = stall_chk;
        ready_mode = 1;
        add_exp(d, s, t, pl, 1'b0);
        start_hdr(d, s, t);
        wait_hdr("t2");
        s_eth_hdr_valid = 1'b0;
        send_payload("t2", pl, 1'b0, -1);
        compare("t2");
        check("t2_stalls_seen", int'(stall_chk > base), 1);

        // tuser on the last beat, then on a middle beat only
        ready_mode = 0;
        for (int k = 0; k < 2; k++) begin
            d = {$urandom, $urandom}; s = {$urandom, $urandom}; t = 16'($urandom);
            rand_payload(pl, 2 + int'($urandom_range(0, 18)));
            add_exp(d, s, t, pl, k == 0);
            start_hdr(d, s, t);
            wait_hdr("t3");
            s_eth_hdr_valid = 1'b0;
            send_payload("t3", pl, k == 0, (k == 0) ? -1 : 0);
            compare($sformatf("t3_user%0d", k));
        end

        // Back-to-back frames with header valid held high
        d = {$urandom, $urandom}; s = {$urandom, $urandom}; t = 16'($urandom);
        d2 = {$urandom, $urandom}; s2 = {$urandom, $urandom}; t2 = 16'($urandom);
        rand_payload(pl, 50);
        rand_payload(pl2, 1 + int'($urandom_range(0, 30)));
        add_exp(d, s, t, pl, 1'b0);
        add_exp(d2, s2, t2, pl2, 1'b1);
        start_hdr(d, s, t);
        wait_hdr("t4a");
        start_hdr(d2, s2, t2);
        tl_base = tl_cnt;
        bu = busy_low;
        watch_busy = 1'b1;
        send_payload("t4a", pl, 1'b0, -1);
        wait_hdr("t4b");
        s_eth_hdr_valid = 1'b0;
        check("t4_hdr_ready_gap", hdr_acc_cyc - pay_last_cyc, 1);
        send_payload("t4b", pl2, 1'b1, -1);
        compare("t4");
        check("t4_busy_held", busy_low - bu, 0);
        watch_busy = 1'b0;

        // Randomized frames under random backpressure
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            bit ul;
            d = {$urandom, $urandom}; s = {$urandom, $urandom}; t = 16'($urandom);
            rand_payload(pl, 1 + int'($urandom_range(0, 59)));
            ul = 1'($urandom_range(0, 1));
            add_exp(d, s, t, pl, ul);
            start_hdr(d, s, t);
            wait_hdr("t5");
            s_eth_hdr_valid = 1'b0;
            send_payload("t5", pl, ul, -1);
            compare($sformatf("t5_rand%0d", k));
        end

        // Asynchronous reset after header byte 5
        ready_mode = 0;
        repeat (4) tick();
        d = {$urandom, $urandom}; s = {$urandom, $urandom}; t = 16'($urandom);
        tl_before = tl_cnt;
        start_hdr(d, s, t);
        wait_hdr("t6");
        s_eth_hdr_valid = 1'b0;
        base = 0;
        while (got.size() - got_rd < 6 && base < 100) begin
            tick();
            base++;
        end
        check("t6_partial_bytes", got.size() - got_rd, 6);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_tvalid", int'(m_axis_tvalid), 0);
        check("t6_async_tdata", int'(m_axis_tdata), 0);
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_hdr_ready", int'(s_eth_hdr_ready), 0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("t6_rel_busy", int'(busy), 0);
        check("t6_rel_hdr_ready", int'(s_eth_hdr_ready), 1);
        check("t6_no_tlast", tl_cnt - tl_before, 0);
        got_rd = got.size();
        exp_q.delete();
        tick();
        rand_payload(pl, 5);
        add_exp(d, s, t, pl, 1'b0);
        start_hdr(d, s, t);
        wait_hdr("t6b");
        s_eth_hdr_valid = 1'b0;
        send_payload("t6b", pl, 1'b0, -1);
        compare("t6_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
